ltc2324_16_emu: RTL

Synthesizable device-side emulator of the LTC2324-16 serial interface: it responds to the CNV/SCK driven by our ADC capture front end and returns CLKOUT plus four SDO lanes carrying 16-bit MSB-first words from an internal pattern source. It sits in place of the real converter, or in a loopback build beside the capture logic. Both closed-loop hardware tests and simulation benches use it to check the full capture → FIFO → AXIS DMA path against known data.

---
 rtl/ltc2324_emu_pkg.sv | 39 +++
 rtl/ltc2324_16_emu_if.sv | 13 +
 rtl/ltc2324_pattern_gen.sv | 37 +++
 rtl/ltc2324_16_emu.sv | 118 +++++++++++
 4 files changed

// File: rtl/ltc2324_emu_pkg.sv
// Shared types and constants for the LTC2324-16 serial interface emulator.
package ltc2324_emu_pkg;

  localparam int NUM_LANES = 4;
  localparam int WORD_W    = 16;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_EXT   = 2'd3
  } pattern_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps on bits 0,2,3,5
  localparam logic [WORD_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [WORD_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [NUM_LANES-1:0][WORD_W-1:0] RAMP_BASE  =
    {16'hC000, 16'h8000, 16'h4000, 16'h0000};
  localparam logic [NUM_LANES-1:0][WORD_W-1:0] CONST_WORD =
    {16'hFFFF, 16'h0000, 16'h5A5A, 16'hA5A5};

  function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] l);
    return {^(l & LFSR_TAPS), l[WORD_W-1:1]};
  endfunction

  function automatic logic [WORD_W-1:0] bitrev16(input logic [WORD_W-1:0] d);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[i] = d[WORD_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/ltc2324_16_emu_if.sv
// Converter-side serial pins: CNV/SCK from the capture front end, CLKOUT/SDO back.
interface ltc2324_16_emu_if;
  logic CNV;
  logic SCK;
  logic CLKOUT;
  logic SDO1;
  logic SDO2;
  logic SDO3;
  logic SDO4;

  modport master (output CNV, SCK, input CLKOUT, SDO1, SDO2, SDO3, SDO4);
  modport slave  (input CNV, SCK, output CLKOUT, SDO1, SDO2, SDO3, SDO4);
endinterface

// File: rtl/ltc2324_pattern_gen.sv
// Four-lane test word source: ramp, constants, LFSR or external words.
module ltc2324_pattern_gen
  import ltc2324_emu_pkg::*;
(
  input  logic                                adc_clk,
  input  logic                                adc_rst_n,
  input  pattern_sel_e                        sel,
  input  logic [NUM_LANES*WORD_W-1:0]         ext_data,
  input  logic [WORD_W-1:0]                   k,
  input  logic                                advance,
  output logic [NUM_LANES-1:0][WORD_W-1:0]    words
);

  logic [WORD_W-1:0] lfsr;

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)   lfsr <= LFSR_SEED;
    else if (advance) lfsr <= lfsr_next(lfsr);
  end

  always_comb begin
    words = '0;
    case (sel)
      PAT_RAMP:  for (int i = 0; i < NUM_LANES; i++) words[i] = RAMP_BASE[i] + k;
      PAT_CONST: words = CONST_WORD;
      PAT_LFSR: begin
        words[0] = lfsr;
        words[1] = ~lfsr;
        words[2] = {lfsr[7:0], lfsr[15:8]};
        words[3] = bitrev16(lfsr);
      end
      PAT_EXT:   words = ext_data;
      default:   words = '0;
    endcase
  end

endmodule

// File: rtl/ltc2324_16_emu.sv
// LTC2324-16 device-side emulator: CNV/SCK synchronizers, conversion FSM and 4-lane SDO shifters.
module ltc2324_16_emu
  import ltc2324_emu_pkg::*;
#(
  parameter int CONV_CYCLES = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        adc_clk,
  input  logic                        adc_rst_n,
  ltc2324_16_emu_if.slave             pins,
  input  logic [1:0]                  pattern_sel,
  input  logic [NUM_LANES*WORD_W-1:0] ext_data,
  output logic                        busy,
  output logic [31:0]                 conv_count,
  output logic                        frame_err
);

  logic [SYNC_STAGES-1:0] cnv_sync, sck_sync;
  logic cnv_d, sck_d;
  logic cnv_rise, sck_fall, start;

  state_e                           state;
  logic [7:0]                       conv_timer;
  logic [4:0]                       bit_cnt;
  logic                             sdo_en;
  logic [NUM_LANES-1:0][WORD_W-1:0] sr;
  logic [NUM_LANES-1:0][WORD_W-1:0] words;
  logic [NUM_LANES-1:0]             sdo;

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      cnv_sync <= '0;
      sck_sync <= '0;
      cnv_d    <= 1'b0;
      sck_d    <= 1'b0;
    end else begin
      cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], pins.CNV};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], pins.SCK};
      cnv_d    <= cnv_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cnv_rise = cnv_sync[SYNC_STAGES-1] & ~cnv_d;
  assign sck_fall = ~sck_sync[SYNC_STAGES-1] & sck_d;
  // A rise while converting is a violation, never a restart
  assign start    = cnv_rise && (state != CONV);

  ltc2324_pattern_gen u_pat (
    .adc_clk   (adc_clk),
    .adc_rst_n (adc_rst_n),
    .sel       (pattern_sel_e'(pattern_sel)),
    .ext_data  (ext_data),
    .k         (conv_count[WORD_W-1:0]),
    .advance   (start),
    .words     (words)
  );

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      conv_count <= '0;
      frame_err  <= 1'b0;
      conv_timer <= '0;
      bit_cnt    <= '0;
      sdo_en     <= 1'b0;
      sr         <= '0;
    end else begin
      frame_err <= 1'b0;
      if (start) begin
        // Same-cycle SCK fall is dropped here without an error
        sr         <= words;
        conv_timer <= 8'(CONV_CYCLES);
        conv_count <= conv_count + 32'd1;
        busy       <= 1'b1;
        sdo_en     <= 1'b0;
        bit_cnt    <= '0;
        state      <= CONV;
      end else begin
        case (state)
          CONV: begin
            if (cnv_rise || sck_fall) frame_err <= 1'b1;
            conv_timer <= conv_timer - 8'd1;
            if (conv_timer == 8'd1) begin
              busy    <= 1'b0;
              sdo_en  <= 1'b1;
              bit_cnt <= '0;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (sck_fall) begin
              if (bit_cnt == 5'd16) frame_err <= 1'b1;
              else begin
                for (int i = 0; i < NUM_LANES; i++) sr[i] <= {sr[i][WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Zero fill on shift means SDO is 0 once all 16 bits are out
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sdo
    assign sdo[g] = sdo_en & sr[g][WORD_W-1];
  end

  assign pins.CLKOUT = sck_d;
  assign pins.SDO1   = sdo[0];
  assign pins.SDO2   = sdo[1];
  assign pins.SDO3   = sdo[2];
  assign pins.SDO4   = sdo[3];

endmodule
